// File: rtl/reg_writeback_buffer.sv
// Register-bank writeback FIFO: merges memory and ALU results, drains one entry
// per cycle into the bank, and exposes pending writes to two bypass lookups.
module reg_writeback_buffer #(
   parameter int DEPTH = 4,
   parameter int DW    = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       mem_valid,
   input  logic [4:0]                 mem_rd,
   input  logic [DW-1:0]              mem_data,
   input  logic                       alu_valid,
   input  logic [4:0]                 alu_rd,
   input  logic [DW-1:0]              alu_data,
   output logic                       in_ready,
   output logic                       wb_write,
   output logic [4:0]                 wb_addr,
   output logic [DW-1:0]              wb_data,
   input  logic [4:0]                 fwd_addr_a,
   input  logic [4:0]                 fwd_addr_b,
   output logic                       fwd_hit_a,
   output logic                       fwd_hit_b,
   output logic [DW-1:0]              fwd_data_a,
   output logic [DW-1:0]              fwd_data_b,
   output logic [$clog2(DEPTH):0]     pending
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   // Two free slots are needed so that a dual push can never overflow.
   localparam logic [CW-1:0] READY_LIMIT = CW'(DEPTH - 2);
   localparam logic [CW-1:0] COUNT_ZERO  = {CW{1'b0}};
   localparam logic [AW-1:0] PTR_ZERO    = {AW{1'b0}};
   localparam logic [AW-1:0] PTR_ONE     = AW'(1);
   localparam logic [DW-1:0] DATA_ZERO   = {DW{1'b0}};

   logic [AW-1:0] head_r;
   logic [AW-1:0] tail_r;
   logic [CW-1:0] count_r;
   logic [4:0]    rd_mem_r   [DEPTH];
   logic [DW-1:0] data_mem_r [DEPTH];

   logic          mem_push_s;
   logic          alu_push_s;
   logic          pop_s;
   logic [AW-1:0] alu_slot_s;
   logic [CW-1:0] push_cnt_s;
   logic [AW-1:0] idx_s;
   logic          live_s;
   logic          match_a_s;
   logic          match_b_s;

   assign in_ready   = (count_r <= READY_LIMIT);
   assign mem_push_s = mem_valid & in_ready & (mem_rd != 5'd0);
   assign alu_push_s = alu_valid & in_ready & (alu_rd != 5'd0);
   assign pop_s      = (count_r != COUNT_ZERO);
   assign alu_slot_s = mem_push_s ? (tail_r + PTR_ONE) : tail_r;
   assign push_cnt_s = CW'(mem_push_s) + CW'(alu_push_s);
   assign wb_write   = pop_s;
   assign pending    = count_r;

   // Pointer and occupancy bookkeeping; reset discards every buffered entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= PTR_ZERO;
         tail_r  <= PTR_ZERO;
         count_r <= COUNT_ZERO;
      end else begin
         if (pop_s) begin
            head_r <= head_r + PTR_ONE;
         end else begin
            head_r <= head_r;
         end
         tail_r  <= tail_r + AW'(push_cnt_s);
         count_r <= count_r + push_cnt_s - CW'(pop_s);
      end
   end

   // Entry storage; the memory result takes the older slot on a dual push.
   always_ff @(posedge clk) begin
      if (mem_push_s) begin
         rd_mem_r[tail_r]   <= mem_rd;
         data_mem_r[tail_r] <= mem_data;
      end
      if (alu_push_s) begin
         rd_mem_r[alu_slot_s]   <= alu_rd;
         data_mem_r[alu_slot_s] <= alu_data;
      end
   end

   // Bank write port presents the head entry, zeroed when the buffer is empty.
   always_comb begin
      wb_addr = 5'd0;
      wb_data = DATA_ZERO;
      if (pop_s) begin
         wb_addr = rd_mem_r[head_r];
         wb_data = data_mem_r[head_r];
      end else begin
         wb_addr = 5'd0;
         wb_data = DATA_ZERO;
      end
   end

   // Bypass search walks oldest to youngest so the last match wins.
   always_comb begin
      fwd_hit_a  = 1'b0;
      fwd_hit_b  = 1'b0;
      fwd_data_a = DATA_ZERO;
      fwd_data_b = DATA_ZERO;
      idx_s      = PTR_ZERO;
      live_s     = 1'b0;
      match_a_s  = 1'b0;
      match_b_s  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         idx_s      = head_r + AW'(i);
         live_s     = (CW'(i) < count_r);
         match_a_s  = live_s & (fwd_addr_a != 5'd0) & (rd_mem_r[idx_s] == fwd_addr_a);
         match_b_s  = live_s & (fwd_addr_b != 5'd0) & (rd_mem_r[idx_s] == fwd_addr_b);
         fwd_hit_a  = fwd_hit_a | match_a_s;
         fwd_hit_b  = fwd_hit_b | match_b_s;
         fwd_data_a = match_a_s ? data_mem_r[idx_s] : fwd_data_a;
         fwd_data_b = match_b_s ? data_mem_r[idx_s] : fwd_data_b;
      end
   end

endmodule

// File: tb/tb_reg_writeback_buffer.sv
// Directed bench for reg_writeback_buffer: fixed vectors plus a queue model
// for the sustained backpressure / wrap stream.
module tb_reg_writeback_buffer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        in_ready;
   logic        wb_write;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [4:0]  fwd_addr_a;
   logic [4:0]  fwd_addr_b;
   logic        fwd_hit_a;
   logic        fwd_hit_b;
   logic [31:0] fwd_data_a;
   logic [31:0] fwd_data_b;
   logic [2:0]  pending;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;
   ent_t q[$];

   reg_writeback_buffer #(.DEPTH(4), .DW(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .in_ready(in_ready), .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
      .fwd_addr_a(fwd_addr_a), .fwd_addr_b(fwd_addr_b),
      .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
      .fwd_data_a(fwd_data_a), .fwd_data_b(fwd_data_b),
      .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 32'h0;
      alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'h0;
   endtask

   // Compare every observable output against the queue model.
   task automatic check_model(input string tag);
      logic        hit;
      logic [31:0] dat;
      hit = 1'b0;
      dat = 32'h0;
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (!hit && fwd_addr_a != 5'd0 && q[i].rd == fwd_addr_a) begin
            hit = 1'b1;
            dat = q[i].data;
         end
      end
      chk({tag, ".pending"},  64'(pending),  64'(q.size()));
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() <= 2));
      chk({tag, ".wb_write"}, 64'(wb_write), 64'(q.size() != 0));
      chk({tag, ".wb_addr"},  64'(wb_addr),  (q.size() != 0) ? 64'(q[0].rd) : 64'h0);
      chk({tag, ".wb_data"},  64'(wb_data),  (q.size() != 0) ? 64'(q[0].data) : 64'h0);
      chk({tag, ".fwd_hit"},  64'(fwd_hit_a),  64'(hit));
      chk({tag, ".fwd_data"}, 64'(fwd_data_a), 64'(dat));
   endtask

   // Model one clock edge: pop the head, then push accepted non-r0 inputs.
   task automatic model_edge();
      logic ready;
      ready = (q.size() <= 2);
      if (q.size() != 0) void'(q.pop_front());
      if (ready && mem_valid && mem_rd != 5'd0) q.push_back({mem_rd, mem_data});
      if (ready && alu_valid && alu_rd != 5'd0) q.push_back({alu_rd, alu_data});
   endtask

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      fwd_addr_a = 5'd0;
      fwd_addr_b = 5'd0;
      #12;
      chk("rst.pending",  64'(pending),  64'h0);
      chk("rst.wb_write", 64'(wb_write), 64'h0);
      chk("rst.in_ready", 64'(in_ready), 64'h1);
      chk("rst.hit_a",    64'(fwd_hit_a), 64'h0);
      chk("rst.hit_b",    64'(fwd_hit_b), 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single push; the same-cycle input must not be forwarded.
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hA5A5_A5A5;
      fwd_addr_a = 5'd5;
      #1;
      chk("single.no_same_cycle_fwd", 64'(fwd_hit_a), 64'h0);
      chk("single.pre_wb_write",      64'(wb_write),  64'h0);
      tick();
      idle_inputs();
      chk("single.wb_write", 64'(wb_write), 64'h1);
      chk("single.wb_addr",  64'(wb_addr),  64'h5);
      chk("single.wb_data",  64'(wb_data),  64'hA5A5_A5A5);
      chk("single.fwd_hit",  64'(fwd_hit_a), 64'h1);
      tick();
      chk("single.drained",  64'(wb_write), 64'h0);
      chk("single.pending0", 64'(pending),  64'h0);

      // Dual push to the same register: mem is older, alu is youngest.
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
      fwd_addr_a = 5'd3;
      tick();
      idle_inputs();
      chk("dual.pending",  64'(pending),    64'h2);
      chk("dual.wb_addr0", 64'(wb_addr),    64'h3);
      chk("dual.wb_data0", 64'(wb_data),    64'h11);
      chk("dual.fwd_hit",  64'(fwd_hit_a),  64'h1);
      chk("dual.fwd_data", 64'(fwd_data_a), 64'h22);
      tick();
      chk("dual.wb_data1",   64'(wb_data),    64'h22);
      chk("dual.head_fwd",   64'(fwd_data_a), 64'h22);
      tick();
      chk("dual.empty_hit",  64'(fwd_hit_a),  64'h0);
      chk("dual.empty_wb",   64'(wb_write),   64'h0);

      // r0 destination is dropped without consuming an entry.
      mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h77;
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
      fwd_addr_b = 5'd0;
      tick();
      idle_inputs();
      chk("r0.pending",  64'(pending),    64'h1);
      chk("r0.wb_addr",  64'(wb_addr),    64'h7);
      chk("r0.wb_data",  64'(wb_data),    64'h77);
      chk("r0.hit_b",    64'(fwd_hit_b),  64'h0);
      chk("r0.data_b",   64'(fwd_data_b), 64'h0);
      tick();
      chk("r0.pending0", 64'(pending),    64'h0);

      // Sustained dual pushes against backpressure, wrapping the pointers.
      q.delete();
      for (int k = 0; k < 24; k++) begin
         mem_valid = 1'b1;
         mem_rd    = (k % 5 == 4) ? 5'd0 : 5'(k % 31 + 1);
         mem_data  = 32'h1000_0000 + 32'(k);
         alu_valid = 1'b1;
         alu_rd    = 5'((k * 3) % 31 + 1);
         alu_data  = 32'h2000_0000 + 32'(k);
         fwd_addr_a = 5'(k % 8 + 1);
         model_edge();
         tick();
         check_model("stream");
      end
      idle_inputs();
      for (int k = 0; k < 6; k++) begin
         model_edge();
         tick();
         check_model("drain");
      end

      // Reset asserted mid-drain with three entries pending.
      mem_valid = 1'b1; mem_rd = 5'd10; mem_data = 32'hA0;
      alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB0;
      tick();
      mem_rd = 5'd12; mem_data = 32'hC0;
      alu_rd = 5'd13; alu_data = 32'hD0;
      tick();
      idle_inputs();
      chk("rmid.pending3", 64'(pending), 64'h3);
      fwd_addr_a = 5'd12;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rmid.wb_write", 64'(wb_write),  64'h0);
      chk("rmid.wb_addr",  64'(wb_addr),   64'h0);
      chk("rmid.wb_data",  64'(wb_data),   64'h0);
      chk("rmid.pending",  64'(pending),   64'h0);
      chk("rmid.in_ready", 64'(in_ready),  64'h1);
      chk("rmid.hit_a",    64'(fwd_hit_a), 64'h0);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rmid.no_stale", 64'(wb_write), 64'h0);
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      tick();
      idle_inputs();
      chk("rmid.fresh_addr", 64'(wb_addr), 64'h9);
      chk("rmid.fresh_data", 64'(wb_data), 64'h99);
      chk("rmid.fresh_pend", 64'(pending), 64'h1);
      tick();
      chk("rmid.fresh_done", 64'(wb_write), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
